// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer
//   4-channel round-robin grant sequencer. It drives a registered 2-bit grant
//   index for a downstream 2-to-4 decoder. A grant is held until it is released,
//   its request drops or it times out. After each grant the block inserts one
//   idle GAP cycle, so the decoder enable always drops between grants.
//
// Parameters
//   TIMEOUT_CYC  maximum number of cycles a grant is held (0 disables timeout)
//   CNT_W        hold-counter width; 2**CNT_W must exceed TIMEOUT_CYC
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_req      request per channel, bit k = channel k
//   i_release  current grantee is done (only looked at while granting)
//   o_sel      granted channel index (registered), feeds decoder i_I
//   o_sel_vld  o_sel is a live grant (registered)
//   o_busy     high in GRANT or GAP (registered)
//   o_timeout  one-cycle pulse when a grant is revoked purely by timeout
module rr_grant_sequencer #(
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_release,
    output logic [1:0] o_sel,
    output logic       o_sel_vld,
    output logic       o_busy,
    output logic       o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam bit                 TO_EN    = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0]   CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    state_t           state_q;
    logic [1:0]       ptr_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             vld_q;
    logic             busy_q;
    logic             tmo_q;

    logic [1:0]       win_d;
    logic [1:0]       idx;
    logic             rel_end;
    logic             drop_end;
    logic             to_end;

    // Round-robin pick: scan from ptr upward with 2-bit wrap. The loop runs
    // from the farthest offset down so the nearest requester overwrites it.
    always_comb begin
        win_d = ptr_q;
        idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (i_req[idx]) begin
                win_d = idx;
            end
        end
    end

    assign rel_end  = i_release;
    assign drop_end = ~i_req[sel_q];
    assign to_end   = TO_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tmo_q <= 1'b0;
                    if (|i_req) begin
                        sel_q   <= win_d;
                        vld_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (rel_end || drop_end || to_end) begin
                        vld_q   <= 1'b0;
                        ptr_q   <= sel_q + 2'd1;
                        // The pulse flags a revocation, not a grant that ended anyway.
                        tmo_q   <= to_end && !rel_end && !drop_end;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    tmo_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    tmo_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sel     = sel_q;
    assign o_sel_vld = vld_q;
    assign o_busy    = busy_q;
    assign o_timeout = tmo_q;

endmodule
